cache_line_refill: RTL and testbench

- Miss-refill engine that sits directly downstream of the cache control FSM.
- When the control FSM enters its load phase, this block fetches the missed line word-by-word from main RAM over a req/ack handshake.
- It writes each word into the direct-mapped cache data array, then writes the tag and valid bit.
- It then pulses fill_done so the control FSM can return to its read/compare phase.

---
 rtl/cache_pkg.sv | 31 +++
 rtl/cache_line_refill_word_ctr.sv | 53 +++++
 rtl/cache_line_refill.sv | 157 +++++++++++++++
 tb/tb_cache_line_refill.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache field widths, address slice helpers and refill state encoding.
// Used by the refill engine and the cache control FSM.
package cache_pkg;

   localparam int unsigned ADDR_W   = 15;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned OFFSET_W = 2;
   localparam int unsigned INDEX_W  = 5;
   localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WRITE = 3'd2,
      ST_TAG   = 3'd3,
      ST_DONE  = 3'd4
   } refill_state_e;

   function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1 -: TAG_W];
   endfunction

   function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
      return a[OFFSET_W +: INDEX_W];
   endfunction

   function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
      return a[OFFSET_W-1:0];
   endfunction

endpackage

// File: rtl/cache_line_refill_word_ctr.sv
// Word-offset counter for a line refill: loads a start offset, increments
// modulo the line size and flags (registered) the final word of the line.
module refill_word_ctr
   import cache_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [OFFSET_W-1:0] load_val,
   input  logic                inc,
   output logic [OFFSET_W-1:0] cnt,
   output logic                last
);

   logic [OFFSET_W-1:0] cnt_q, cnt_d;
   logic [OFFSET_W-1:0] start_q, start_d;
   logic                last_q, last_d;
   logic [OFFSET_W-1:0] cnt_nxt;
   logic [OFFSET_W-1:0] start_m1;

   always_comb begin
      cnt_d    = cnt_q;
      start_d  = start_q;
      last_d   = last_q;
      cnt_nxt  = cnt_q + 1'b1;
      start_m1 = start_q - 1'b1;
      if (load) begin
         cnt_d   = load_val;
         start_d = load_val;
         last_d  = 1'b0;
      end else if (inc) begin
         cnt_d  = cnt_nxt;
         // the word just before the start offset (mod line size) closes the line
         last_d = (cnt_nxt == start_m1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         start_q <= '0;
         last_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         start_q <= start_d;
         last_q  <= last_d;
      end
   end

   assign cnt  = cnt_q;
   assign last = last_q;

endmodule

// File: rtl/cache_line_refill.sv
// Miss-refill engine: fetches a cache line word by word from RAM, writes the
// data array, then tag/valid. CRITICAL_WORD_FIRST_EN starts at the miss offset.
module cache_line_refill
   import cache_pkg::*;
(
   input  logic                globalclock,
   input  logic                reset,
   input  logic                fill_req,
   input  logic [ADDR_W-1:0]   miss_addr,
   output logic                fill_busy,
   output logic                fill_done,
   output logic                mem_req,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic                mem_ack,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                line_wr_en,
   output logic [INDEX_W-1:0]  line_index,
   output logic [OFFSET_W-1:0] line_offset,
   output logic [DATA_W-1:0]   line_wr_data,
   output logic                tag_wr_en,
`ifdef CRITICAL_WORD_FIRST_EN
   output logic                crit_valid,
`endif
   output logic [TAG_W-1:0]    tag_wr_data
);

   refill_state_e       state_q, state_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [INDEX_W-1:0]  idx_q, idx_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [OFFSET_W-1:0] cnt;
   logic                last;
   logic                ctr_load;
   logic                ctr_inc;
   logic [OFFSET_W-1:0] start_off;

`ifdef CRITICAL_WORD_FIRST_EN
   logic first_q, first_d;
   assign start_off = addr_offset(miss_addr);
`else
   logic unused_miss_offset;
   assign start_off          = '0;
   assign unused_miss_offset = ^addr_offset(miss_addr);
`endif

   assign ctr_load = (state_q == ST_IDLE) && fill_req;
   assign ctr_inc  = (state_q == ST_WRITE) && !last;

   refill_word_ctr u_word_ctr (
      .clk      (globalclock),
      .rst_n    (reset),
      .load     (ctr_load),
      .load_val (start_off),
      .inc      (ctr_inc),
      .cnt      (cnt),
      .last     (last)
   );

   always_ff @(posedge globalclock or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (fill_req) state_d = ST_REQ;
         ST_REQ:   if (mem_ack)  state_d = ST_WRITE;
         ST_WRITE: state_d = last ? ST_TAG : ST_REQ;
         ST_TAG:   state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      tag_d  = tag_q;
      idx_d  = idx_q;
      data_d = data_q;
      if (ctr_load) begin
         tag_d = addr_tag(miss_addr);
         idx_d = addr_index(miss_addr);
      end
      if ((state_q == ST_REQ) && mem_ack) data_d = mem_rdata;
   end

`ifdef CRITICAL_WORD_FIRST_EN
   always_comb begin
      first_d = first_q;
      if (ctr_load)                   first_d = 1'b1;
      else if (state_q == ST_WRITE)   first_d = 1'b0;
   end
`endif

   always_ff @(posedge globalclock or negedge reset) begin
      if (!reset) begin
         tag_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
`ifdef CRITICAL_WORD_FIRST_EN
         first_q <= 1'b0;
`endif
      end else begin
         tag_q   <= tag_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
`ifdef CRITICAL_WORD_FIRST_EN
         first_q <= first_d;
`endif
      end
   end

   // outputs decode state and registered fields only
   always_comb begin
      fill_busy    = 1'b0;
      fill_done    = 1'b0;
      mem_req      = 1'b0;
      mem_addr     = '0;
      line_wr_en   = 1'b0;
      line_index   = idx_q;
      line_offset  = '0;
      line_wr_data = '0;
      tag_wr_en    = 1'b0;
      tag_wr_data  = '0;
`ifdef CRITICAL_WORD_FIRST_EN
      crit_valid   = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: ;
         ST_REQ: begin
            fill_busy = 1'b1;
            mem_req   = 1'b1;
            mem_addr  = {tag_q, idx_q, cnt};
         end
         ST_WRITE: begin
            fill_busy    = 1'b1;
            line_wr_en   = 1'b1;
            line_offset  = cnt;
            line_wr_data = data_q;
`ifdef CRITICAL_WORD_FIRST_EN
            crit_valid   = first_q;
`endif
         end
         ST_TAG: begin
            fill_busy   = 1'b1;
            tag_wr_en   = 1'b1;
            tag_wr_data = tag_q;
         end
         ST_DONE: begin
            fill_busy = 1'b1;
            fill_done = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cache_line_refill.sv
// Scoreboard bench for cache_line_refill: stimulus pushes expected RAM
// addresses, line writes, tag writes and done cycles; a monitor pops and checks.
`timescale 1ns/1ps
module tb_cache_line_refill;
   import cache_pkg::*;

   logic                globalclock = 1'b0;
   logic                reset       = 1'b0;
   logic                fill_req    = 1'b0;
   logic [ADDR_W-1:0]   miss_addr   = '0;
   logic                fill_busy;
   logic                fill_done;
   logic                mem_req;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_ack     = 1'b0;
   logic [DATA_W-1:0]   mem_rdata   = '0;
   logic                line_wr_en;
   logic [INDEX_W-1:0]  line_index;
   logic [OFFSET_W-1:0] line_offset;
   logic [DATA_W-1:0]   line_wr_data;
   logic                tag_wr_en;
   logic [TAG_W-1:0]    tag_wr_data;
`ifdef CRITICAL_WORD_FIRST_EN
   logic                crit_valid;
`endif

   cache_line_refill dut (
      .globalclock  (globalclock),
      .reset        (reset),
      .fill_req     (fill_req),
      .miss_addr    (miss_addr),
      .fill_busy    (fill_busy),
      .fill_done    (fill_done),
      .mem_req      (mem_req),
      .mem_addr     (mem_addr),
      .mem_ack      (mem_ack),
      .mem_rdata    (mem_rdata),
      .line_wr_en   (line_wr_en),
      .line_index   (line_index),
      .line_offset  (line_offset),
      .line_wr_data (line_wr_data),
      .tag_wr_en    (tag_wr_en),
`ifdef CRITICAL_WORD_FIRST_EN
      .crit_valid   (crit_valid),
`endif
      .tag_wr_data  (tag_wr_data)
   );

   always #5 globalclock = ~globalclock;

   int cyc = 0;
   always @(posedge globalclock) cyc <= cyc + 1;

   typedef struct {
      int                  cyc;
      logic [INDEX_W-1:0]  idx;
      logic [OFFSET_W-1:0] off;
      logic [DATA_W-1:0]   data;
      bit                  crit;
   } wr_t;
   typedef struct {
      int               cyc;
      logic [TAG_W-1:0] tag;
   } tag_t;

   wr_t               exp_wr[$];
   tag_t              exp_tag[$];
   logic [ADDR_W-1:0] exp_addr[$];
   int                exp_done[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic fail_line(input string name);
      checks++;
      errors++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // RAM model: data is the low address byte XOR 5A
   function automatic logic [DATA_W-1:0] ram_data(input logic [ADDR_W-1:0] a);
      return a[7:0] ^ 8'h5A;
   endfunction

   int wait_n    = 0;
   int wcnt      = 0;
   bit stray_ack = 1'b0;

   always @(posedge globalclock) begin
      #1;
      if (mem_req) begin
         if (wcnt >= wait_n) begin
            mem_ack   = 1'b1;
            mem_rdata = ram_data(mem_addr);
            wcnt      = 0;
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = '0;
            wcnt++;
         end
      end else begin
         mem_ack   = stray_ack;
         mem_rdata = 8'hEE;
         wcnt      = 0;
      end
   end

   always @(negedge globalclock) begin
      if (mem_req) begin
         if (exp_addr.size() == 0) fail_line("mem_req unexpected");
         else begin
            chk("mem_addr", mem_addr, exp_addr[0]);
            if (mem_ack) void'(exp_addr.pop_front());
         end
      end
      if (line_wr_en) begin
         if (exp_wr.size() == 0) fail_line("line_wr_en unexpected");
         else begin
            wr_t e;
            e = exp_wr.pop_front();
            chk("write cycle", cyc, e.cyc);
            chk("line_index", line_index, e.idx);
            chk("line_offset", line_offset, e.off);
            chk("line_wr_data", line_wr_data, e.data);
`ifdef CRITICAL_WORD_FIRST_EN
            chk("crit_valid", crit_valid, e.crit);
`endif
         end
      end
`ifdef CRITICAL_WORD_FIRST_EN
      if (crit_valid && !line_wr_en) fail_line("crit_valid outside write");
`endif
      if (tag_wr_en) begin
         if (exp_tag.size() == 0) fail_line("tag_wr_en unexpected");
         else begin
            tag_t t;
            t = exp_tag.pop_front();
            chk("tag cycle", cyc, t.cyc);
            chk("tag_wr_data", tag_wr_data, t.tag);
         end
      end
      if (fill_done) begin
         if (exp_done.size() == 0) fail_line("fill_done unexpected");
         else chk("fill_done cycle", cyc, exp_done.pop_front());
      end
   end

   task automatic chk_outputs_zero(input string name);
      chk(name, {fill_busy, fill_done, mem_req, mem_addr, line_wr_en, line_index,
                 line_offset, line_wr_data, tag_wr_en, tag_wr_data}, '0);
`ifdef CRITICAL_WORD_FIRST_EN
      chk({name, " crit"}, crit_valid, 1'b0);
`endif
   endtask

   // Issues a fill seen in cycle t0 and queues its expected responses.
   task automatic start_fill(input logic [ADDR_W-1:0] a, input logic [TAG_W-1:0] tag,
                             input logic [INDEX_W-1:0] idx, input int w, input int start,
                             input int nwords, input int naddr, output int t0);
      logic [OFFSET_W-1:0] off;
      @(posedge globalclock);
      #1;
      wait_n    = w;
      miss_addr = a;
      fill_req  = 1'b1;
      t0        = cyc;
      for (int k = 0; k < naddr; k++) begin
         off = OFFSET_W'((start + k) % 4);
         exp_addr.push_back({a[ADDR_W-1:OFFSET_W], off});
      end
      for (int k = 0; k < nwords; k++) begin
         off = OFFSET_W'((start + k) % 4);
         exp_wr.push_back('{t0 + (w + 2) * (k + 1), idx, off,
                            ram_data({a[ADDR_W-1:OFFSET_W], off}), (k == 0)});
      end
      if (nwords == 4) begin
         exp_tag.push_back('{t0 + 4 * (w + 2) + 1, tag});
         exp_done.push_back(t0 + 4 * (w + 2) + 2);
      end
      @(posedge globalclock);
      #1;
      fill_req  = 1'b0;
      miss_addr = ~a;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (fill_busy !== 1'b0 && n < budget) begin
         @(posedge globalclock);
         #1;
         n++;
      end
      if (n >= budget) fail_line("timeout waiting for idle");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0;
      repeat (3) @(posedge globalclock);
      #1;
      chk_outputs_zero("reset outputs");
      @(negedge globalclock);
      reset = 1'b1;

      // basic fill, zero-wait RAM
      start_fill(15'h1234, 8'h24, 5'h0D, 0, 0, 4, 4, t0);
      wait_idle(50);
      chk("idle at t0+11", cyc, t0 + 11);

      // three wait cycles per word
      start_fill(15'h5A68, 8'hB4, 5'h1A, 3, 0, 4, 4, t0);
      wait_idle(100);
      chk("idle at t0+23", cyc, t0 + 23);

      // async reset during the write of word 2
      start_fill(15'h7F10, 8'hFE, 5'h04, 0, 0, 2, 3, t0);
      repeat (5) @(posedge globalclock);
      #1;
      chk("write of word 2", line_offset, 2'd2);
      #1;
      reset = 1'b0;
      #1;
      chk_outputs_zero("mid-fill reset outputs");
      repeat (2) @(negedge globalclock);
      reset = 1'b1;
      start_fill(15'h1234, 8'h24, 5'h0D, 0, 0, 4, 4, t0);
      wait_idle(50);

      // fill_req during REQ is ignored; stray ack in IDLE captures nothing
      start_fill(15'h5A68, 8'hB4, 5'h1A, 0, 0, 4, 4, t0);
      @(posedge globalclock);
      @(posedge globalclock);
      #1;
      fill_req = 1'b1;
      @(posedge globalclock);
      #1;
      fill_req = 1'b0;
      wait_idle(50);
      stray_ack = 1'b1;
      repeat (3) @(posedge globalclock);
      #1;
      stray_ack = 1'b0;
      repeat (2) @(posedge globalclock);
      #1;
      chk("busy after stray ack", fill_busy, 1'b0);

`ifdef CRITICAL_WORD_FIRST_EN
      // critical word first: order 2,3,0,1
      start_fill(15'h1236, 8'h24, 5'h0D, 0, 2, 4, 4, t0);
      wait_idle(50);
      chk("cwf idle at t0+11", cyc, t0 + 11);
`endif

      repeat (3) @(posedge globalclock);
      #1;
      chk("pending addr", exp_addr.size(), 0);
      chk("pending writes", exp_wr.size(), 0);
      chk("pending tags", exp_tag.size(), 0);
      chk("pending done", exp_done.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
